// File: rtl/tx_req_fifo.sv
`timescale 1ns / 1ps
`default_nettype none
// ============================================================================
// tx_req_fifo : req-pulse handshake FIFO between a Tx word source and sink
// Revision    : 1.0
// ============================================================================
module tx_req_fifo #(
   parameter int DATA_WIDTH = 8,
   parameter int DEPTH      = 4,
   parameter int HOLDOFF    = 4,
   localparam int BITS_W    = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1,
   localparam int LVL_W     = $clog2(DEPTH) + 1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [DATA_WIDTH-1:0] in_data,
   input  logic                  in_data_valid,
   input  logic [BITS_W-1:0]     in_data_bits,
   output logic                  in_req,
   output logic [DATA_WIDTH-1:0] out_data,
   output logic                  out_data_valid,
   output logic [BITS_W-1:0]     out_data_bits,
   input  logic                  out_req,
   output logic [LVL_W-1:0]      level,
   output logic                  err_underflow
);

   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int HO_W  = $clog2(HOLDOFF + 1);
   localparam int ENT_W = DATA_WIDTH + BITS_W;

   localparam logic [LVL_W-1:0] LVL_FULL = LVL_W'(DEPTH);
   localparam logic [LVL_W-1:0] LVL_ONE  = LVL_W'(1);
   localparam logic [HO_W-1:0]  HO_LOAD  = HO_W'(HOLDOFF);
   localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);

   logic [ENT_W-1:0]  mem [DEPTH];
   logic [PTR_W-1:0]  wr_ptr;
   logic [PTR_W-1:0]  rd_ptr;
   logic [HO_W-1:0]   holdoff;
   logic [BITS_W-1:0] in_bits_eff;
   logic [ENT_W-1:0]  in_entry;
   logic [ENT_W-1:0]  next_entry;
   logic [ENT_W-1:0]  head_next;
   logic              head_load;
   logic              wr_en;
   logic              pop_en;

   generate
      if (DATA_WIDTH > 1) begin : g_bits
         assign in_bits_eff = in_data_bits;
      end else begin : g_no_bits
         // Single-bit words carry no partial count; the port is accepted but dropped.
         logic unused_bits;
         assign unused_bits = ^in_data_bits;
         assign in_bits_eff = '0;
      end
   endgenerate

   // Space is judged on the pre-edge level, so a same-edge pop never frees a slot.
   assign wr_en          = in_data_valid && (level != LVL_FULL) && (holdoff == '0);
   assign pop_en         = out_req && (level != '0);
   assign in_entry       = {in_data, in_bits_eff};
   assign next_entry     = mem[rd_ptr + PTR_ONE];
   assign out_data_valid = (level != '0);

   // The presented head is a separate register; it only moves on a pop or on
   // the first write into an empty FIFO, keeping out_* stable otherwise.
   always_comb begin
      head_load = 1'b0;
      head_next = '0;
      if (pop_en) begin
         head_load = 1'b1;
         if (level > LVL_ONE) begin
            head_next = next_entry;
         end else if (wr_en) begin
            head_next = in_entry;
         end else begin
            head_next = '0;
         end
      end else if (wr_en && (level == '0)) begin
         head_load = 1'b1;
         head_next = in_entry;
      end
   end

   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem[wr_ptr] <= in_entry;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr        <= '0;
         rd_ptr        <= '0;
         level         <= '0;
         holdoff       <= '0;
         in_req        <= 1'b0;
         out_data      <= '0;
         out_data_bits <= '0;
         err_underflow <= 1'b0;
      end else begin
         in_req <= wr_en;

         if (wr_en) begin
            wr_ptr <= wr_ptr + PTR_ONE;
         end
         if (pop_en) begin
            rd_ptr <= rd_ptr + PTR_ONE;
         end

         case ({wr_en, pop_en})
            2'b10:   level <= level + LVL_ONE;
            2'b01:   level <= level - LVL_ONE;
            default: level <= level;
         endcase

         if (wr_en) begin
            holdoff <= HO_LOAD;
         end else if (holdoff != '0) begin
            holdoff <= holdoff - HO_W'(1);
         end

         if (head_load) begin
            {out_data, out_data_bits} <= head_next;
         end

         if (out_req && (level == '0)) begin
            err_underflow <= 1'b1;
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_tx_req_fifo.sv
`timescale 1ns / 1ps
`default_nettype none
// ============================================================================
// tb_tx_req_fifo : directed + random checks of tx_req_fifo against a queue model
// Revision       : 1.0
// ============================================================================
module tb_tx_req_fifo;

   localparam int DEPTH   = 4;
   localparam int HOLDOFF = 4;

   logic       clk = 1'b0;
   logic       rst;
   logic [7:0] in_data;
   logic       in_data_valid;
   logic [2:0] in_data_bits;
   logic       in_req;
   logic [7:0] out_data;
   logic       out_data_valid;
   logic [2:0] out_data_bits;
   logic       out_req;
   logic [2:0] level;
   logic       err_underflow;

   logic [0:0] b_in_data;
   logic [0:0] b_in_bits;
   logic       b_in_valid;
   logic       b_in_req;
   logic [0:0] b_out_data;
   logic [0:0] b_out_bits;
   logic       b_out_valid;
   logic       b_out_req;
   logic [2:0] b_level;
   logic       b_err;

   always #5 clk = ~clk;

   tx_req_fifo #(.DATA_WIDTH(8), .DEPTH(DEPTH), .HOLDOFF(HOLDOFF)) dut (
      .clk(clk), .rst(rst),
      .in_data(in_data), .in_data_valid(in_data_valid), .in_data_bits(in_data_bits),
      .in_req(in_req),
      .out_data(out_data), .out_data_valid(out_data_valid), .out_data_bits(out_data_bits),
      .out_req(out_req), .level(level), .err_underflow(err_underflow)
   );

   tx_req_fifo #(.DATA_WIDTH(1), .DEPTH(4), .HOLDOFF(4)) dut_bit (
      .clk(clk), .rst(rst),
      .in_data(b_in_data), .in_data_valid(b_in_valid), .in_data_bits(b_in_bits),
      .in_req(b_in_req),
      .out_data(b_out_data), .out_data_valid(b_out_valid), .out_data_bits(b_out_bits),
      .out_req(b_out_req), .level(b_level), .err_underflow(b_err)
   );

   typedef struct packed {
      logic [7:0] d;
      logic [2:0] b;
   } ent_t;

   ent_t mq[$];
   ent_t src[$];
   int   cyc;
   int   last_wr;
   logic m_in_req;
   logic m_err;
   int   total = 0;
   int   bad   = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      mq.delete();
      last_wr  = -1000;
      m_in_req = 1'b0;
      m_err    = 1'b0;
   endtask

   task automatic drive_src();
      if (src.size() > 0) begin
         in_data_valid = 1'b1;
         in_data       = src[0].d;
         in_data_bits  = src[0].b;
      end else begin
         in_data_valid = 1'b0;
      end
   endtask

   task automatic check_outputs();
      chk("level", 32'(level), 32'(mq.size()));
      chk("out_valid", 32'(out_data_valid), 32'(mq.size() != 0));
      chk("out_data", 32'(out_data), (mq.size() != 0) ? 32'(mq[0].d) : 32'd0);
      chk("out_bits", 32'(out_data_bits), (mq.size() != 0) ? 32'(mq[0].b) : 32'd0);
      chk("in_req", 32'(in_req), 32'(m_in_req));
      chk("err_underflow", 32'(err_underflow), 32'(m_err));
   endtask

   // One clock: model consumes the pre-edge inputs, DUT is checked 1 ns after the edge.
   task automatic tick(input logic req);
      bit   wr;
      bit   pop;
      ent_t e;
      wr      = 1'b0;
      pop     = 1'b0;
      out_req = req;
      drive_src();
      if (rst) begin
         model_reset();
      end else begin
         wr  = in_data_valid && (mq.size() < DEPTH) && (cyc - last_wr > HOLDOFF);
         pop = req && (mq.size() > 0);
         if (req && mq.size() == 0) m_err = 1'b1;
         if (pop) void'(mq.pop_front());
         if (wr) begin
            e.d = in_data;
            e.b = in_data_bits;
            mq.push_back(e);
            last_wr = cyc;
         end
         m_in_req = wr;
      end
      cyc++;
      @(posedge clk);
      #1;
      out_req = 1'b0;
      check_outputs();
      if (wr) void'(src.pop_front());
      drive_src();
   endtask

   task automatic push_src(input logic [7:0] d, input logic [2:0] b);
      ent_t e;
      e.d = d;
      e.b = b;
      src.push_back(e);
   endtask

   initial begin
      logic [3:0] pat;
      logic       prev_req;
      logic       req;
      int         guard;

      rst           = 1'b1;
      out_req       = 1'b0;
      in_data       = '0;
      in_data_valid = 1'b0;
      in_data_bits  = '0;
      b_in_data     = '0;
      b_in_bits     = '0;
      b_in_valid    = 1'b0;
      b_out_req     = 1'b0;
      cyc           = 0;
      model_reset();

      repeat (2) tick(1'b0);
      rst = 1'b0;
      tick(1'b0);

      // Three full-byte words with an idle sink.
      push_src(8'hA5, 3'd0);
      push_src(8'h3C, 3'd0);
      push_src(8'h0F, 3'd0);
      repeat (16) tick(1'b0);
      chk("stream_level", 32'(level), 32'd3);
      chk("stream_head", 32'(out_data), 32'hA5);
      tick(1'b1);
      chk("stream_pop1", 32'(out_data), 32'h3C);
      tick(1'b0);
      tick(1'b1);
      chk("stream_pop2", 32'(out_data), 32'h0F);
      tick(1'b0);
      tick(1'b1);
      chk("stream_empty_valid", 32'(out_data_valid), 32'd0);
      chk("stream_empty_data", 32'(out_data), 32'd0);

      // Six words into a four-entry FIFO.
      for (int i = 0; i < 6; i++) push_src(8'($urandom_range(0, 255)), 3'd0);
      repeat (40) tick(1'b0);
      chk("fill_level", 32'(level), 32'd4);
      tick(1'b1);
      repeat (6) tick(1'b0);
      chk("fill_refill_level", 32'(level), 32'd4);
      guard = 0;
      while ((mq.size() > 0 || src.size() > 0) && guard < 100) begin
         tick(1'b1);
         repeat (5) tick(1'b0);
         guard++;
      end
      chk("fill_drain_bound", 32'(guard < 100), 32'd1);
      repeat (6) tick(1'b0);

      // Partial word, then write+pop on the same edge at level 1.
      push_src(8'h05, 3'd3);
      repeat (6) tick(1'b0);
      chk("partial_data", 32'(out_data), 32'h05);
      chk("partial_bits", 32'(out_data_bits), 32'd3);
      push_src(8'h77, 3'd0);
      tick(1'b1);
      chk("simul_level", 32'(level), 32'd1);
      chk("simul_head", 32'(out_data), 32'h77);
      tick(1'b0);
      tick(1'b1);
      tick(1'b0);
      tick(1'b1);
      chk("underflow_err", 32'(err_underflow), 32'd1);
      chk("underflow_level", 32'(level), 32'd0);

      // Asynchronous reset while holding three entries.
      push_src(8'h11, 3'd1);
      push_src(8'h22, 3'd2);
      push_src(8'h33, 3'd0);
      repeat (14) tick(1'b0);
      chk("pre_reset_level", 32'(level), 32'd3);
      rst = 1'b1;
      #1;
      model_reset();
      src.delete();
      drive_src();
      chk("async_rst_level", 32'(level), 32'd0);
      chk("async_rst_valid", 32'(out_data_valid), 32'd0);
      chk("async_rst_in_req", 32'(in_req), 32'd0);
      chk("async_rst_err", 32'(err_underflow), 32'd0);
      tick(1'b0);
      rst = 1'b0;
      tick(1'b0);

      // Random traffic; sink never requests on consecutive cycles.
      prev_req = 1'b0;
      for (int i = 0; i < 400; i++) begin
         if ($urandom_range(0, 3) == 0 && src.size() < 3)
            push_src(8'($urandom_range(0, 255)), 3'($urandom_range(0, 7)));
         req = !prev_req && ($urandom_range(0, 2) == 0);
         tick(req);
         prev_req = req;
      end
      src.delete();
      drive_src();

      // Bit-wide instance: pattern 1,0,1,1.
      pat = 4'b1101;
      b_in_valid = 1'b1;
      for (int i = 0; i < 4; i++) begin
         int w;
         b_in_data = pat[i];
         b_in_bits = 1'($urandom_range(0, 1));
         w = 0;
         do begin
            @(posedge clk);
            #1;
            w++;
         end while (!b_in_req && w < 20);
         chk("bit_in_req_seen", 32'(b_in_req), 32'd1);
      end
      b_in_valid = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk("bit_level", 32'(b_level), 32'd4);
      for (int i = 0; i < 4; i++) begin
         chk("bit_data", 32'(b_out_data), 32'(pat[i]));
         chk("bit_bits", 32'(b_out_bits), 32'd0);
         b_out_req = 1'b1;
         @(posedge clk);
         #1;
         b_out_req = 1'b0;
         @(posedge clk);
         #1;
      end
      chk("bit_empty_valid", 32'(b_out_valid), 32'd0);
      chk("bit_err", 32'(b_err), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
